// File: rtl/sound_sequencer.sv
// Piezo arbiter: plays the colour-display tone or a fixed per-event jingle as one
// square wave, with latched event requests served by priority.
module sound_sequencer #(
  parameter int unsigned NOTE_CYCLES = 2500000,
  parameter logic [15:0] BASE_HALF   = 16'd5000,
  parameter logic [15:0] STEP_HALF   = 16'd500
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] COLOR,
  input  logic       COLOR_ENA,
  input  logic       START_REQ,
  input  logic       HS_REQ,
  input  logic       WIN_REQ,
  input  logic       LOSE_REQ,
  input  logic       MUTE,
  output logic       SPK,
  output logic       SND_ENA,
  output logic [2:0] NOTE,
  output logic       BUSY
);

  localparam int unsigned NCW = (NOTE_CYCLES > 2) ? $clog2(NOTE_CYCLES) : 1;
  localparam int unsigned HW  = 16;

  // Jingle ids double as bit positions in the pending/request vectors
  localparam logic [1:0] J_START = 2'd0;
  localparam logic [1:0] J_HS    = 2'd1;
  localparam logic [1:0] J_WIN   = 2'd2;
  localparam logic [1:0] J_LOSE  = 2'd3;

  typedef enum logic [1:0] {IDLE, TONE, JINGLE} state_t;

  state_t           state_q, state_d;
  logic [1:0]       jingle_q, jingle_d;
  logic [1:0]       pos_q, pos_d;
  logic [NCW-1:0]   ncnt_q, ncnt_d;
  logic [HW-1:0]    div_q, div_d;
  logic             phase_q, phase_d;
  logic [3:0]       pending_q, pending_d;
  logic [3:0]       req;
  logic [2:0]       note_d;
  logic [HW-1:0]    half_d;
  logic             reload;
  logic             start_jingle;

  function automatic logic [2:0] jingle_note(input logic [1:0] j, input logic [1:0] pos);
    case (j)
      J_START: jingle_note = {pos, 1'b0};
      J_HS:    jingle_note = 3'd7;
      J_WIN:   jingle_note = 3'd4 + {1'b0, pos};
      default: jingle_note = 3'd3 - {1'b0, pos};
    endcase
  endfunction

  function automatic logic [1:0] last_pos(input logic [1:0] j);
    case (j)
      J_START: last_pos = 2'd2;
      J_HS:    last_pos = 2'd0;
      default: last_pos = 2'd3;
    endcase
  endfunction

  function automatic logic [1:0] pick(input logic [3:0] r);
    if (r[J_LOSE])      pick = J_LOSE;
    else if (r[J_WIN])  pick = J_WIN;
    else if (r[J_START]) pick = J_START;
    else                pick = J_HS;
  endfunction

  // Next-state, sequencing and divider logic
  always_comb begin
    req          = pending_q | {LOSE_REQ, WIN_REQ, HS_REQ, START_REQ};
    state_d      = state_q;
    jingle_d     = jingle_q;
    pos_d        = pos_q;
    ncnt_d       = ncnt_q;
    pending_d    = req;
    note_d       = NOTE;
    reload       = 1'b0;
    start_jingle = 1'b0;
    half_d       = '0;
    div_d        = div_q;
    phase_d      = phase_q;

    case (state_q)
      IDLE: begin
        if (|req) begin
          start_jingle = 1'b1;
        end else if (COLOR_ENA) begin
          state_d = TONE;
          note_d  = {COLOR, 1'b0};
          reload  = 1'b1;
        end
      end
      TONE: begin
        if (|req) begin
          start_jingle = 1'b1;
        end else if (!COLOR_ENA) begin
          state_d = IDLE;
        end else begin
          note_d = {COLOR, 1'b0};
          reload = (note_d != NOTE);
        end
      end
      JINGLE: begin
        if (ncnt_q == NCW'(NOTE_CYCLES - 1)) begin
          if (pos_q == last_pos(jingle_q)) begin
            if (|req) begin
              start_jingle = 1'b1;
            end else if (COLOR_ENA) begin
              state_d = TONE;
              note_d  = {COLOR, 1'b0};
              reload  = 1'b1;
            end else begin
              state_d = IDLE;
            end
          end else begin
            pos_d  = pos_q + 2'd1;
            ncnt_d = '0;
            note_d = jingle_note(jingle_q, pos_d);
            reload = 1'b1;
          end
        end else begin
          ncnt_d = ncnt_q + NCW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_jingle) begin
      state_d   = JINGLE;
      jingle_d  = pick(req);
      pos_d     = '0;
      ncnt_d    = '0;
      note_d    = jingle_note(jingle_d, 2'd0);
      reload    = 1'b1;
      pending_d = req & ~(4'b0001 << jingle_d);
    end

    if (state_d == IDLE) note_d = '0;

    // Square-wave divider; phase held low whenever silent
    half_d = BASE_HALF - (HW'(note_d) * STEP_HALF);
    if (state_d == IDLE) begin
      div_d   = '0;
      phase_d = 1'b0;
    end else if (reload) begin
      div_d = half_d - HW'(1);
    end else if (div_q == '0) begin
      div_d   = half_d - HW'(1);
      phase_d = ~phase_q;
    end else begin
      div_d = div_q - HW'(1);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      jingle_q  <= '0;
      pos_q     <= '0;
      ncnt_q    <= '0;
      div_q     <= '0;
      phase_q   <= 1'b0;
      pending_q <= '0;
      SPK       <= 1'b0;
      SND_ENA   <= 1'b0;
      NOTE      <= '0;
      BUSY      <= 1'b0;
    end else begin
      state_q   <= state_d;
      jingle_q  <= jingle_d;
      pos_q     <= pos_d;
      ncnt_q    <= ncnt_d;
      div_q     <= div_d;
      phase_q   <= phase_d;
      pending_q <= pending_d;
      SPK       <= phase_d & ~MUTE;
      SND_ENA   <= (state_d != IDLE);
      NOTE      <= note_d;
      BUSY      <= (state_d == JINGLE) | (pending_d != '0);
    end
  end

endmodule

// File: tb/tb_sound_sequencer.sv
// Bench for sound_sequencer: directed scenarios plus random traffic against a
// queue-based reference model of the arbiter and its square-wave output.
module tb_sound_sequencer;

  localparam int NC = 8;
  localparam int BH = 10;
  localparam int SH = 1;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [1:0] COLOR = 2'd0;
  logic       COLOR_ENA = 1'b0;
  logic       START_REQ = 1'b0;
  logic       HS_REQ = 1'b0;
  logic       WIN_REQ = 1'b0;
  logic       LOSE_REQ = 1'b0;
  logic       MUTE = 1'b0;
  logic       SPK;
  logic       SND_ENA;
  logic [2:0] NOTE;
  logic       BUSY;

  sound_sequencer #(
    .NOTE_CYCLES(NC),
    .BASE_HALF(16'(BH)),
    .STEP_HALF(16'(SH))
  ) dut (
    .CLK(CLK), .RST(RST), .COLOR(COLOR), .COLOR_ENA(COLOR_ENA),
    .START_REQ(START_REQ), .HS_REQ(HS_REQ), .WIN_REQ(WIN_REQ), .LOSE_REQ(LOSE_REQ),
    .MUTE(MUTE), .SPK(SPK), .SND_ENA(SND_ENA), .NOTE(NOTE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  // Reference model: jingle = per-cycle note queue; tone/idle decided from inputs
  int jtab[4][4] = '{'{0, 2, 4, -1}, '{7, -1, -1, -1}, '{4, 5, 6, 7}, '{3, 2, 1, 0}};
  int sseq[3] = '{0, 2, 4};
  int wseq[5] = '{4, 5, 6, 7, 7};
  int lseq[7] = '{0, 2, 4, 3, 2, 1, 0};
  int rem[$];
  int m_mode = 0;
  int m_note = 0;
  int m_p0 = 0;
  int m_s = 0;
  int m_half = BH;
  int m_phase = 0;
  logic [3:0] m_pend = '0;
  logic m_spk = 1'b0;
  logic [5:0] exp_v;
  logic [5:0] act_v;

  task automatic model_step();
    int prev_mode, prev_note, prev_phase, j;
    bit restart;
    logic [3:0] r;
    prev_mode  = m_mode;
    prev_note  = m_note;
    prev_phase = m_phase;
    restart    = 1'b0;
    if (RST) begin
      m_mode = 0; m_note = 0; m_pend = '0; m_phase = 0; m_spk = 1'b0;
      rem.delete();
    end else begin
      r = m_pend | {LOSE_REQ, WIN_REQ, HS_REQ, START_REQ};
      if (m_mode == 2 && rem.size() > 1) begin
        void'(rem.pop_front());
        m_note  = rem[0];
        m_pend  = r;
        restart = (rem.size() % NC) == 0;
      end else if (r != 0) begin
        j = r[3] ? 3 : r[2] ? 2 : r[0] ? 0 : 1;
        rem.delete();
        for (int i = 0; i < 4; i++)
          if (jtab[j][i] >= 0) repeat (NC) rem.push_back(jtab[j][i]);
        m_mode  = 2;
        m_note  = rem[0];
        m_pend  = r & ~(4'b0001 << j);
        restart = 1'b1;
      end else if (COLOR_ENA) begin
        m_mode  = 1;
        m_note  = 2 * int'(COLOR);
        m_pend  = r;
        restart = (prev_mode != 1) || (m_note != prev_note);
      end else begin
        m_mode = 0; m_note = 0; m_pend = r;
      end
      if (m_mode == 0) begin
        m_phase = 0;
      end else if (restart) begin
        m_p0 = prev_phase; m_s = 0; m_half = BH - SH * m_note; m_phase = m_p0;
      end else begin
        m_s++;
        m_phase = m_p0 ^ ((m_s / m_half) % 2);
      end
      m_spk = (m_phase != 0) && !MUTE;
    end
    exp_v = {m_spk, m_mode != 0, 3'(m_note), (m_mode == 2) || (m_pend != 0)};
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
    act_v = {SPK, SND_ENA, NOTE, BUSY};
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    checks++;
    if (act_v !== 6'b0) begin
      errors++; $display("FAIL reset_outputs: got %b expected %b", act_v, 6'b0);
    end
    RST = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      checks++;
      if (act_v !== 6'b0) begin
        errors++; $display("FAIL reset_hold k=%0d: got %b expected %b", k, act_v, 6'b0);
      end
    end
  endtask

  task automatic test_tone();
    COLOR = 2'd2; COLOR_ENA = 1'b1;
    for (int k = 0; k < 24; k++) begin
      tick();
      checks++;
      if ({SND_ENA, NOTE} !== 4'b1100) begin
        errors++; $display("FAIL tone_note k=%0d: got %b expected 1100", k, {SND_ENA, NOTE});
      end
      checks++;
      if (SPK !== 1'((k / 6) % 2)) begin
        errors++; $display("FAIL tone_spk k=%0d: got %b expected %0d", k, SPK, (k / 6) % 2);
      end
    end
    COLOR = 2'd3;
    tick();
    checks++;
    if (NOTE !== 3'd6) begin
      errors++; $display("FAIL tone_color_change: got %0d expected 6", NOTE);
    end
    for (int k = 0; k < 12; k++) begin
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL tone_half4 k=%0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    COLOR_ENA = 1'b0;
    tick();
    checks++;
    if ({SPK, SND_ENA, NOTE} !== 5'b0) begin
      errors++; $display("FAIL tone_fall: got %b expected 00000", {SPK, SND_ENA, NOTE});
    end
  endtask

  task automatic test_start();
    for (int k = 0; k < 24; k++) begin
      START_REQ = (k == 0);
      tick();
      checks++;
      if ({SND_ENA, BUSY, NOTE} !== {2'b11, 3'(sseq[k / 8])}) begin
        errors++; $display("FAIL start_seq k=%0d: got %b expected %b", k, {SND_ENA, BUSY, NOTE}, {2'b11, 3'(sseq[k / 8])});
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL start_model k=%0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    START_REQ = 1'b0;
    tick();
    checks++;
    if (act_v !== 6'b0) begin
      errors++; $display("FAIL start_end: got %b expected %b", act_v, 6'b0);
    end
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 32; k++) begin
      START_REQ = (k == 0);
      HS_REQ    = (k == 24);
      tick();
      checks++;
      if ({SND_ENA, NOTE} !== {1'b1, 3'(k < 24 ? sseq[k / 8] : 7)}) begin
        errors++; $display("FAIL b2b_seq k=%0d: got %b", k, {SND_ENA, NOTE});
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL b2b_model k=%0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    HS_REQ = 1'b0;
    tick();
    checks++;
    if (act_v !== 6'b0) begin
      errors++; $display("FAIL b2b_end: got %b expected %b", act_v, 6'b0);
    end
  endtask

  task automatic test_win_hs();
    COLOR = 2'd1; COLOR_ENA = 1'b1;
    tick();
    checks++;
    if ({SND_ENA, NOTE} !== 4'b1010) begin
      errors++; $display("FAIL winhs_tone: got %b expected 1010", {SND_ENA, NOTE});
    end
    for (int k = 0; k < 40; k++) begin
      WIN_REQ = (k == 0); HS_REQ = (k == 0);
      tick();
      checks++;
      if ({SND_ENA, NOTE} !== {1'b1, 3'(wseq[k / 8])}) begin
        errors++; $display("FAIL winhs_seq k=%0d: got %b expected %b", k, {SND_ENA, NOTE}, {1'b1, 3'(wseq[k / 8])});
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL winhs_model k=%0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    WIN_REQ = 1'b0; HS_REQ = 1'b0;
    tick();
    checks++;
    if ({SND_ENA, NOTE, BUSY} !== 5'b10100) begin
      errors++; $display("FAIL winhs_resume: got %b expected 10100", {SND_ENA, NOTE, BUSY});
    end
    COLOR_ENA = 1'b0;
    tick();
    checks++;
    if (act_v !== exp_v) begin
      errors++; $display("FAIL winhs_off: got %b expected %b", act_v, exp_v);
    end
  endtask

  task automatic test_lose_during_start();
    for (int k = 0; k < 56; k++) begin
      START_REQ = (k == 0);
      LOSE_REQ  = (k == 10);
      tick();
      checks++;
      if ({SND_ENA, BUSY, NOTE} !== {2'b11, 3'(lseq[k / 8])}) begin
        errors++; $display("FAIL lose_seq k=%0d: got %b expected %b", k, {SND_ENA, BUSY, NOTE}, {2'b11, 3'(lseq[k / 8])});
      end
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL lose_model k=%0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    LOSE_REQ = 1'b0;
    tick();
  endtask

  task automatic test_mute_reset();
    MUTE = 1'b1;
    for (int k = 0; k < 32; k++) begin
      WIN_REQ = (k == 0);
      tick();
      checks++;
      if ({SPK, SND_ENA, NOTE} !== {2'b01, 3'(wseq[k / 8])}) begin
        errors++; $display("FAIL mute_win k=%0d: got %b expected %b", k, {SPK, SND_ENA, NOTE}, {2'b01, 3'(wseq[k / 8])});
      end
    end
    WIN_REQ = 1'b0; MUTE = 1'b0;
    tick();
    for (int k = 0; k < 12; k++) begin
      LOSE_REQ = (k == 0); START_REQ = (k == 5);
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL midlose_model k=%0d: got %b expected %b", k, act_v, exp_v);
      end
    end
    LOSE_REQ = 1'b0; START_REQ = 1'b0; RST = 1'b1;
    tick();
    checks++;
    if (act_v !== 6'b0) begin
      errors++; $display("FAIL rst_midlose: got %b expected %b", act_v, 6'b0);
    end
    RST = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      checks++;
      if (act_v !== 6'b0) begin
        errors++; $display("FAIL rst_no_replay k=%0d: got %b expected %b", k, act_v, 6'b0);
      end
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 2000; k++) begin
      START_REQ = ($urandom_range(0, 29) == 0);
      HS_REQ    = ($urandom_range(0, 29) == 0);
      WIN_REQ   = ($urandom_range(0, 39) == 0);
      LOSE_REQ  = ($urandom_range(0, 39) == 0);
      RST       = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 59) == 0) COLOR_ENA = ~COLOR_ENA;
      if ($urandom_range(0, 19) == 0) COLOR = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 99) == 0) MUTE = ~MUTE;
      tick();
      checks++;
      if (act_v !== exp_v) begin
        errors++; $display("FAIL random k=%0d: got %b expected %b", k, act_v, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_tone();
    test_start();
    test_back_to_back();
    test_win_hs();
    test_lose_during_start();
    test_mute_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sound_sequencer.md
# sound_sequencer

Arbitrates the single piezo speaker between the game controller's colour-display tone and its event jingles (start, score, win, lose). It sits between the game controller and the speaker pin. It takes the colour/enable pair the controller drives during display, plus single-cycle event pulses. From these it produces one square wave at a time, playing a fixed note sequence per event.

## Interface
- NOTE_CYCLES, 2500000: duration of one jingle note, in clock cycles; must be ≥ 2.
- BASE_HALF, 16'd5000: half-period in cycles of note 0.
- STEP_HALF, 16'd500: half-period decrement per note index. Note k half-period is BASE_HALF − k·STEP_HALF. Constraint: BASE_HALF > 7·STEP_HALF.
- CLK  in  1  clock; all logic is on the rising edge.
- RST  in  1  synchronous reset, active-high.
- COLOR  in  2  colour currently being displayed.
- COLOR_ENA  in  1  level; high while a colour is displayed.
- START_REQ, HS_REQ, WIN_REQ, LOSE_REQ  in  1 each  single-cycle event pulses.
- MUTE  in  1  level; silences SPK only.
- SPK  out  1  square-wave speaker drive.
- SND_ENA  out  1  high while any note is sounding.
- NOTE  out  3  index of the note currently sounding; 0 when silent.
- BUSY  out  1  high while a jingle is playing or any request is pending.

## Operation
- Reset: SPK, SND_ENA, NOTE and BUSY are 0. Pending bits, the note counter and the divider are cleared. The FSM goes to IDLE.
- Request latch: each *_REQ pulse sets its pending bit. The effective request is req = pending | pulse, so a pulse is served without an extra cycle.
  - A pending bit clears on the edge its jingle starts.
  - A request arriving while its own jingle plays is latched and played again afterwards.
- Priority among effective requests: LOSE > WIN > START > HS.
- Jingles (note indices, each note NOTE_CYCLES long, no gaps):
  - START: 0, 2, 4
  - HS: 7
  - WIN: 4, 5, 6, 7
  - LOSE: 3, 2, 1, 0
- Colour tone: colour c plays note 2c.
- FSM states and transitions:
  - IDLE: any req → JINGLE, taking the highest-priority request. Otherwise COLOR_ENA → TONE. Otherwise stay.
  - TONE: any req → JINGLE; the tone is preempted. Otherwise, !COLOR_ENA → IDLE. Otherwise NOTE follows 2·COLOR, and a COLOR change takes effect on the next edge.
  - JINGLE: a running jingle is never preempted. After the last cycle of its last note, the FSM goes to JINGLE (next request by priority) if any req, otherwise to TONE if COLOR_ENA, otherwise to IDLE.
- Divider:
  - Entering any sounding state, or changing note, loads the down-counter with half−1.
  - On reaching 0 the counter reloads and the internal phase toggles.
  - The phase is forced to 0 while silent, so every sound starts low.
  - A note change reloads the counter but does not reset the phase.
- SPK = phase & !MUTE. MUTE does not affect SND_ENA, NOTE, BUSY or sequencing.
- BUSY = (state == JINGLE) | (pending != 0).

## Timing
- Request pulse on edge t: SND_ENA=1 and NOTE=first note from edge t+1.
- COLOR_ENA rise: SND_ENA and NOTE update on the next edge.
- COLOR_ENA fall: SND_ENA=0, NOTE=0 and SPK=0 on the next edge.
- Jingle length: exactly (notes × NOTE_CYCLES) cycles of SND_ENA. Back-to-back jingles keep SND_ENA high throughout with no gap cycle.
- SPK period is 2·half cycles. The first rising edge of SPK comes half cycles after sound starts.
- Simultaneous pulses are all latched and served in priority order. A pulse on the same cycle as a jingle's last cycle is served next, by priority.
- RST asserted mid-jingle: all outputs are 0 on the next edge and pending requests are discarded.

## Test plan
Bench parameters for all scenarios: NOTE_CYCLES=8, BASE_HALF=10, STEP_HALF=1.

1. Reset with all inputs 0 → SPK, SND_ENA, NOTE and BUSY are all 0. Hold for 20 cycles → they stay 0.
2. COLOR=2 with COLOR_ENA rising at cycle 0:
   - From cycle 1: NOTE=4 and SND_ENA=1; SPK is low for 6 cycles, then high for 6, repeating.
   - COLOR→3 → NOTE=6 next edge, half-period 4.
   - COLOR_ENA fall → SND_ENA=0 and SPK=0 next edge.
3. START_REQ pulse from IDLE:
   - NOTE sequence is 0, 2, 4, each for 8 cycles; SND_ENA and BUSY are high for 24 cycles.
   - Then return to IDLE with all outputs 0.
4. WIN_REQ and HS_REQ in the same cycle while COLOR_ENA=1 with COLOR=1:
   - WIN plays notes 4, 5, 6, 7 (32 cycles), then HS plays note 7 (8 cycles), then the tone resumes at NOTE=2.
   - SND_ENA never drops over this interval.
5. LOSE_REQ pulse during the second note of START:
   - START completes all 24 cycles; BUSY stays high throughout.
   - LOSE then plays notes 3, 2, 1, 0.
6. MUTE=1 throughout a WIN jingle → SPK=0 while NOTE and SND_ENA match the unmuted run. Then, with MUTE low, assert RST mid-LOSE → all outputs are 0 next edge and no request replays afterwards.
